ppcpu_mdu: RTL and testbench

PPCPU_MDU -- requirements
Module: ppcpu_mdu

---
 rtl/ppcpu_mdu_if.sv | 29 ++
 rtl/ppcpu_mdu.sv | 153 +++++++++++++++
 tb/tb_ppcpu_mdu.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ppcpu_mdu_if.sv
// Request/result bundle between the CPU pipeline and the multiply/divide unit.
// Latency: n/a (signal bundle only).
// Backpressure: requester must hold off new work while Busy is high; Start then is ignored.
// Ports: master drives Start/Op/A/B/Flush and observes Busy/Done/Hi/Lo/DivZero;
//        slave is the unit side with the opposite directions.
interface ppcpu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             DivZero;

  modport master (
    output Start, Op, A, B, Flush,
    input  Busy, Done, Hi, Lo, DivZero
  );

  modport slave (
    input  Start, Op, A, B, Flush,
    output Busy, Done, Hi, Lo, DivZero
  );
endinterface

// File: rtl/ppcpu_mdu.sv
// Iterative multiply/divide unit (MULTU, MULT, DIVU, DIV) on operand magnitudes with a sign fix-up cycle.
// Latency: fixed; Done pulses in the cycle after edge WIDTH+2 (edge 0 accepts Start), for every Op.
// Backpressure: Busy high while computing; Start is ignored then, accepted again in IDLE or DONE.
// Ports: Clk (rising edge), Rst (async active-high), bus (slave side of ppcpu_mdu_if:
//        Start/Op/A/B/Flush in; Busy/Done/Hi/Lo/DivZero out).
module ppcpu_mdu #(
  parameter int WIDTH = 32
) (
  input logic         Clk,
  input logic         Rst,
  ppcpu_mdu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;         // [1]: divide, [0]: signed
  logic [WIDTH-1:0] a_q;          // raw dividend kept for the divide-by-zero result
  logic             sign_b;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_hi;       // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;       // product lower half / dividend-then-quotient
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dz_q;
  logic             busy, done;

  logic             accept, calc_last, sign_a;
  logic [WIDTH-1:0] mag_a_in, mag_b_in, mul_addend, div_sub;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_dz;

  assign accept    = (state == IDLE || state == DONE) && bus.Start && !bus.Flush;
  assign calc_last = (cnt == CW'(WIDTH));
  assign mag_a_in  = (bus.Op[0] && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign mag_b_in  = (bus.Op[0] && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // Multiply step: add multiplicand when the LSB of the shifting multiplier is set, then shift right.
  assign mul_addend = acc_lo[0] ? mag_b : '0;
  assign mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};

  // Restoring divide step: shift next dividend bit into the remainder and trial-subtract.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mag_b});
  assign div_sub   = div_shift[WIDTH-1:0] - mag_b;

  // Sign fix-up applied in FIX; divide by zero bypasses the iterated result entirely.
  assign sign_a   = op_q[0] & a_q[WIDTH-1];
  assign prod_neg = -{acc_hi, acc_lo};

  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    res_dz = 1'b0;
    if (!op_q[1]) begin
      if (sign_a ^ sign_b) {res_hi, res_lo} = prod_neg;
    end else if (mag_b == '0) begin
      res_hi = a_q;
      res_lo = '1;
      res_dz = 1'b1;
    end else begin
      // Truncation toward zero: quotient sign from both operands, remainder follows the dividend.
      if (sign_a ^ sign_b) res_lo = -acc_lo;
      if (sign_a)          res_hi = -acc_hi;
    end
  end

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; Flush wins over everything, including a simultaneous Start.
  always_comb begin
    state_nxt = state;
    if (bus.Flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.Start) state_nxt = CALC;
        CALC:    if (calc_last) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = bus.Start ? CALC : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  // Datapath: operand latch, one iteration per CALC cycle, result load when leaving FIX.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_q   <= '0;
      a_q    <= '0;
      sign_b <= 1'b0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= bus.Op;
        a_q    <= bus.A;
        sign_b <= bus.Op[0] & bus.B[WIDTH-1];
        mag_b  <= mag_b_in;
        acc_hi <= '0;
        acc_lo <= mag_a_in;
        cnt    <= '0;
      end else if (state == CALC && !bus.Flush && !calc_last) begin
        cnt <= cnt + 1'b1;
        if (!op_q[1]) begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (div_ge) begin
          acc_hi <= div_sub;
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end
      if (state == FIX && !bus.Flush) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
        dz_q <= res_dz;
      end
    end
  end

  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign bus.DivZero = dz_q;
endmodule

// File: tb/tb_ppcpu_mdu.sv
// Directed self-checking bench for ppcpu_mdu at WIDTH=32.
// Latency: checks the fixed WIDTH+2 Done latency on every operation.
// Backpressure: exercises Start during Busy, back-to-back Start in Done, Flush and mid-op reset.
module tb_ppcpu_mdu;
  localparam int W = 32;

  logic Clk;
  logic Rst;
  int   checks   = 0;
  int   failures = 0;
  int   cnt_done;
  int   cnt_busy;

  ppcpu_mdu_if #(.WIDTH(W)) bus ();

  ppcpu_mdu #(.WIDTH(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    drive_op(op, a, b);
  endtask

  // Called at the negedge following the accepting edge (cycle n=0); runs until Done or a 100-cycle bound.
  task automatic collect(input string tag, input int poke,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dz);
    int n     = 0;
    int nbusy = 0;
    while (bus.Done !== 1'b1 && n < 100) begin
      if (bus.Busy === 1'b1) nbusy++;
      if (n == poke) begin
        bus.Start = 1'b1;
        bus.Op    = 2'b00;
        bus.A     = 32'hFFFF_FFFF;
        bus.B     = 32'hFFFF_FFFF;
      end
      if (n == poke + 3) bus.Start = 1'b0;
      @(negedge Clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(W + 2));
    check({tag, " busy_cycles"}, 64'(nbusy), 64'(W + 2));
    check({tag, " busy_in_done"}, 64'(bus.Busy), 64'd0);
    check({tag, " hi"}, 64'(bus.Hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.Lo), 64'(exp_lo));
    check({tag, " divzero"}, 64'(bus.DivZero), 64'(exp_dz));
  endtask

  task automatic wait_done(input string tag, input int poke,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dz);
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    collect(tag, poke, exp_hi, exp_lo, exp_dz);
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    bus.Flush = 1'b0;
    Rst       = 1'b0;

    // Asynchronous reset, observed before any clock edge.
    #2 Rst = 1'b1;
    #1;
    check("rst busy", 64'(bus.Busy), 64'd0);
    check("rst done", 64'(bus.Done), 64'd0);
    check("rst hi", 64'(bus.Hi), 64'd0);
    check("rst lo", 64'(bus.Lo), 64'd0);
    check("rst divzero", 64'(bus.DivZero), 64'd0);

    // First Start honoured on the first edge after reset falls.
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    drive_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", -1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge Clk);
    check("done_pulse_width", 64'(bus.Done), 64'd0);
    check("idle_after_done", 64'(bus.Busy), 64'd0);

    start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg3x5", -1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

    start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg7by2", -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    start_op(2'b10, 32'd10, 32'd0);
    wait_done("divu_by0", -1, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1);

    start_op(2'b10, 32'd10, 32'd3);
    wait_done("divu_10by3", -1, 32'd1, 32'd3, 1'b0);

    start_op(2'b11, 32'hFFFF_FFFB, 32'd0);
    wait_done("div_neg5by0", -1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min_by_m1", -1, 32'd0, 32'h8000_0000, 1'b0);

    start_op(2'b01, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min_sq", -1, 32'h4000_0000, 32'd0, 1'b0);

    // Back-to-back: Start presented in the Done cycle.
    start_op(2'b00, 32'h1234_5678, 32'h0000_0010);
    wait_done("multu_shift4", -1, 32'd1, 32'h2345_6780, 1'b0);
    drive_op(2'b00, 32'd6, 32'd7);
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    check("b2b busy", 64'(bus.Busy), 64'd1);
    check("b2b no_done", 64'(bus.Done), 64'd0);
    check("b2b hold_hi", 64'(bus.Hi), 64'd1);
    check("b2b hold_lo", 64'(bus.Lo), 64'h2345_6780);
    collect("b2b_6x7", -1, 32'd0, 32'd42, 1'b0);

    // Start (with different operands) while busy must not disturb the operation.
    start_op(2'b10, 32'd100, 32'd7);
    wait_done("divu_poke", 5, 32'd2, 32'd14, 1'b0);

    // Flush at cycle 10 of CALC.
    start_op(2'b00, 32'h0000_1234, 32'h0000_5678);
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge Clk);
    bus.Flush = 1'b1;
    @(negedge Clk);
    bus.Flush = 1'b0;
    check("flush busy", 64'(bus.Busy), 64'd0);
    cnt_done = 0;
    repeat (40) begin
      if (bus.Done === 1'b1) cnt_done++;
      @(negedge Clk);
    end
    check("flush no_done", 64'(cnt_done), 64'd0);
    check("flush hold_hi", 64'(bus.Hi), 64'd2);
    check("flush hold_lo", 64'(bus.Lo), 64'd14);

    // Flush beats a simultaneous Start in IDLE.
    drive_op(2'b00, 32'd3, 32'd3);
    bus.Flush = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    check("flush_prio busy", 64'(bus.Busy), 64'd0);
    @(negedge Clk);
    check("flush_prio idle", 64'(bus.Busy), 64'd0);

    // Reset at cycle 10 of CALC, applied between clock edges.
    start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("midrst busy", 64'(bus.Busy), 64'd0);
    check("midrst done", 64'(bus.Done), 64'd0);
    check("midrst hi", 64'(bus.Hi), 64'd0);
    check("midrst lo", 64'(bus.Lo), 64'd0);
    check("midrst divzero", 64'(bus.DivZero), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    cnt_done = 0;
    cnt_busy = 0;
    repeat (40) begin
      if (bus.Done === 1'b1) cnt_done++;
      if (bus.Busy === 1'b1) cnt_busy++;
      @(negedge Clk);
    end
    check("midrst no_done", 64'(cnt_done), 64'd0);
    check("midrst no_busy", 64'(cnt_busy), 64'd0);

    start_op(2'b01, 32'hFFFF_FFFF, 32'd7);
    wait_done("mult_m1x7", -1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
